// File: rtl/ext_mem_spi_master_if.sv
// rtl/ext_mem_spi_master_if.sv - start/done handshake bundle between requester and ext_mem_spi_master
// Signals:
//   start, wr_addr[7:0], wr_data[7:0]  requester -> SPI master
//   busy, done, rd_data[7:0]           SPI master -> requester
//   txn_count[15:0]                    SPI master -> requester, only with SPI_TXN_COUNT_EN
// Modports: master = requester side, slave = ext_mem_spi_master side.
interface ext_mem_spi_master_if;
  logic       start;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
`ifdef SPI_TXN_COUNT_EN
  logic [15:0] txn_count;

  modport master (output start, wr_addr, wr_data, input busy, done, rd_data, txn_count);
  modport slave  (input start, wr_addr, wr_data, output busy, done, rd_data, txn_count);
`else
  modport master (output start, wr_addr, wr_data, input busy, done, rd_data);
  modport slave  (input start, wr_addr, wr_data, output busy, done, rd_data);
`endif
endinterface

// File: rtl/ext_mem_spi_master.sv
// rtl/ext_mem_spi_master.sv - mode-0 SPI master doing an atomic two-byte swap frame on external memory
// Ports:
//   clk, reset_n         system clock, asynchronous active-low reset
//   bus (slave modport)  start/wr_addr/wr_data in, busy/done/rd_data out
//   CS, SCLK, MOSI       SPI outputs (CS active-low, SCLK idle low, MSB first)
//   MISO                 SPI input, sampled on rising SCLK during the data byte
// Optional: define SPI_TXN_COUNT_EN to add bus.txn_count, a wrapping count of
// completed frames.
module ext_mem_spi_master #(
  parameter int CLK_DIV   = 4,
  parameter int GAP_HALF  = 4,
  parameter int HOLD_HALF = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  ext_mem_spi_master_if.slave  bus,
  output logic                 CS,
  output logic                 SCLK,
  output logic                 MOSI,
  input  logic                 MISO
);
  localparam int DW   = $clog2(CLK_DIV);
  localparam int HMAX = (GAP_HALF > 16) ? ((GAP_HALF > HOLD_HALF) ? GAP_HALF : HOLD_HALF)
                                        : ((HOLD_HALF > 16) ? HOLD_HALF : 16);
  localparam int HW   = $clog2(HMAX);

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_SHIFT_ADDR, S_GAP, S_SHIFT_DATA, S_CS_HOLD, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [HW-1:0]   half_q, half_d;
  logic [7:0]      tx_q, tx_d;     // MOSI shift register; MOSI is always tx_q[7]
  logic [7:0]      data_q, data_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      rd_q, rd_d;
  logic            cs_q, cs_d;
  logic            sclk_q, sclk_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            tick;
`ifdef SPI_TXN_COUNT_EN
  logic [15:0]     cnt_q, cnt_d;
`endif

  always_comb begin
    tick    = (div_q == DW'(CLK_DIV - 1));
    state_d = state_q;
    div_d   = '0;
    half_d  = half_q;
    tx_d    = tx_q;
    data_d  = data_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SPI_TXN_COUNT_EN
    cnt_d   = cnt_q;
`endif
    // The half-period divider only runs while a frame is in flight.
    if (state_q != S_IDLE && state_q != S_DONE) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          tx_d    = bus.wr_addr;
          data_d  = bus.wr_data;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          half_d  = '0;
          state_d = S_CS_SETUP;
        end
      end
      S_CS_SETUP: begin
        if (tick) begin
          half_d  = '0;
          state_d = S_SHIFT_ADDR;
        end
      end
      S_SHIFT_ADDR, S_SHIFT_DATA: begin
        // Even half-periods end with a rising edge, odd ones with a falling
        // edge, so the first half-period of each byte is SCLK-low setup time.
        if (tick) begin
          half_d = half_q + 1'b1;
          if (!half_q[0]) begin
            sclk_d = 1'b1;
            if (state_q == S_SHIFT_DATA) rx_d = {rx_q[6:0], MISO};
          end else begin
            sclk_d = 1'b0;
            tx_d   = {tx_q[6:0], 1'b0};
            if (half_q == HW'(15)) begin
              half_d = '0;
              if (state_q == S_SHIFT_ADDR) begin
                tx_d    = data_q;
                state_d = S_GAP;
              end else begin
                rd_d    = rx_q;
                cs_d    = 1'b1;
                tx_d    = '0;
                state_d = S_CS_HOLD;
              end
            end
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          half_d = half_q + 1'b1;
          if (half_q == HW'(GAP_HALF - 1)) begin
            half_d  = '0;
            state_d = S_SHIFT_DATA;
          end
        end
      end
      S_CS_HOLD: begin
        if (tick) begin
          half_d = half_q + 1'b1;
          if (half_q == HW'(HOLD_HALF - 1)) begin
            half_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
`ifdef SPI_TXN_COUNT_EN
        cnt_d   = cnt_q + 16'd1;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      half_q  <= '0;
      tx_q    <= '0;
      data_q  <= '0;
      rx_q    <= '0;
      rd_q    <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SPI_TXN_COUNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      tx_q    <= tx_d;
      data_q  <= data_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SPI_TXN_COUNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign CS          = cs_q;
  assign SCLK        = sclk_q;
  assign MOSI        = tx_q[7];
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_data = rd_q;
`ifdef SPI_TXN_COUNT_EN
  assign bus.txn_count = cnt_q;
`endif
endmodule

// File: tb/tb_ext_mem_spi_master.sv
// tb/tb_ext_mem_spi_master.sv - scoreboard bench for ext_mem_spi_master with a behavioural SPI memory slave
module tb_ext_mem_spi_master;
  localparam int CLK_DIV   = 4;
  localparam int GAP_HALF  = 4;
  localparam int HOLD_HALF = 2;
  localparam int LAT       = CLK_DIV * (1 + 16 + GAP_HALF + 16 + HOLD_HALF);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cs, sclk, mosi, miso;

  ext_mem_spi_master_if bus();

  ext_mem_spi_master #(.CLK_DIV(CLK_DIV), .GAP_HALF(GAP_HALF), .HOLD_HALF(HOLD_HALF)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .CS(cs), .SCLK(sclk), .MOSI(mosi), .MISO(miso)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] addr; logic [7:0] data; logic [7:0] exp_rd; } txn_t;
  typedef struct { logic [7:0] addr; logic [7:0] data; } cap_t;

  txn_t       sb[$];
  cap_t       cap_q[$];
  logic [7:0] model_mem [256];
  int         errs = 0;
  int         checks = 0;
  int         exp_cnt = 0;

  function automatic logic [7:0] init_val(input int i);
    return (i == 8'h12) ? 8'h3C : (8'(i) ^ 8'h5A);
  endfunction

  // Memory slave: oversamples CS/SCLK on clk, shifts MOSI in on rising SCLK,
  // presents old contents on MISO during byte 1, commits only on a full frame.
  logic [7:0] smem [256];
  logic       sl_init = 1'b0;
  logic       sl_cs = 1'b1, sl_sclk = 1'b0;
  int         s_bits = 0;
  logic [7:0] s_sh = '0, s_addr = '0, s_tx = '0;
  logic       s_miso = 1'b0;
  assign miso = s_miso;

  always @(posedge clk) begin
    sl_cs   <= cs;
    sl_sclk <= sclk;
    if (!sl_init) begin
      for (int i = 0; i < 256; i++) smem[i] <= init_val(i);
      sl_init <= 1'b1;
    end else if (cs && !sl_cs) begin
      if (s_bits == 16) begin
        smem[s_addr] <= s_sh;
        cap_q.push_back('{s_addr, s_sh});
      end
      s_bits <= 0;
    end else if (!cs && sl_cs) begin
      s_bits <= 0;
      s_miso <= 1'b0;
    end else if (!cs) begin
      if (sclk && !sl_sclk) begin
        s_sh   <= {s_sh[6:0], mosi};
        s_bits <= s_bits + 1;
        if (s_bits == 7) begin
          s_addr <= {s_sh[6:0], mosi};
          s_tx   <= smem[{s_sh[6:0], mosi}];
          s_miso <= smem[{s_sh[6:0], mosi}][7];
        end
      end
      if (!sclk && sl_sclk && s_bits > 8 && s_bits < 16) begin
        s_tx   <= {s_tx[6:0], 1'b0};
        s_miso <= s_tx[6];
      end
    end
  end

  // Protocol monitor: SCLK quiet while CS high, CS never moves under high SCLK,
  // CS-high run length between frames, SCLK-low run before the 9th rising edge.
  logic p_cs = 1'b1, p_sclk = 1'b0;
  int   viol = 0, cs_hi = 0, last_hi = 0, rise = 0, low_run = 0, gap_min = 1000, done_cnt = 0;

  always @(negedge clk) begin
    if (p_cs && cs && (sclk !== p_sclk)) viol <= viol + 1;
    if ((cs !== p_cs) && p_sclk && sclk) viol <= viol + 1;
    if (cs) begin
      cs_hi <= cs_hi + 1;
    end else begin
      cs_hi <= 0;
      if (p_cs) begin
        last_hi <= cs_hi;
        rise    <= 0;
        low_run <= sclk ? 0 : 1;
      end else begin
        if (sclk && !p_sclk) begin
          rise <= rise + 1;
          if (rise == 8 && low_run < gap_min) gap_min <= low_run;
        end
        low_run <= sclk ? 0 : low_run + 1;
      end
    end
    p_cs   <= cs;
    p_sclk <= sclk;
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
`ifdef SPI_TXN_COUNT_EN
    check("txn_count", bus.txn_count, exp_cnt);
`endif
  endtask

  // Caller is positioned #1 after a rising edge with the DUT idle.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] d,
                         input int inject_at, input int abort_at);
    txn_t t;
    cap_t c;
    int   n;
    t.addr = a; t.data = d; t.exp_rd = model_mem[a];
    model_mem[a] = d;
    sb.push_back(t);
    bus.wr_addr = a; bus.wr_data = d; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("cs_after_start", cs, 0);
    n = 0;
    while (n < LAT + 50) begin
      @(posedge clk); #1;
      n++;
      bus.start = 1'b0;
      if (n == inject_at) begin
        bus.wr_addr = 8'h40; bus.wr_data = 8'hEE; bus.start = 1'b1;
      end
      if (n == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("abort_cs", cs, 1);
        check("abort_sclk", sclk, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_rd_data", bus.rd_data, 0);
        t = sb.pop_front();
        model_mem[t.addr] = t.exp_rd;
        exp_cnt = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check("abort_mem_kept", smem[t.addr], model_mem[t.addr]);
        check("abort_no_commit", cap_q.size(), 0);
        return;
      end
      if (bus.done) break;
    end
    check("latency", n, LAT);
    check("busy_at_done", bus.busy, 0);
    if (bus.done && sb.size() > 0) begin
      t = sb.pop_front();
      exp_cnt++;
      check("rd_data", bus.rd_data, t.exp_rd);
      if (cap_q.size() > 0) begin
        c = cap_q.pop_front();
        check("mosi_addr", c.addr, t.addr);
        check("mosi_data", c.data, t.data);
      end else begin
        check("slave_commit_seen", 0, 1);
      end
      check("slave_mem", smem[t.addr], t.data);
    end
  endtask

  initial begin
    int dc0;
    logic [7:0] ra, rd;
    bus.start = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    for (int i = 0; i < 256; i++) model_mem[i] = init_val(i);
    repeat (4) @(posedge clk);
    #1;
    check("rst_cs", cs, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rd_data", bus.rd_data, 0);
`ifdef SPI_TXN_COUNT_EN
    check("rst_txn_count", bus.txn_count, 0);
`endif
    reset_n = 1'b1;
    next_cycle();

    run_txn(8'h12, 8'hA5, -1, -1);
    next_cycle();
    run_txn(8'h12, 8'h5A, -1, -1);
    check("cs_high_between_frames", (last_hi >= 2 * CLK_DIV), 1);
    next_cycle();

    dc0 = done_cnt;
    run_txn(8'h33, 8'hC3, 20, -1);
    repeat (200) @(posedge clk);
    #1;
    check("single_done", done_cnt - dc0, 1);
    check("ignored_addr_mem", smem[8'h40], model_mem[8'h40]);
    next_cycle();

    run_txn(8'h77, 8'h11, -1, 105);
    next_cycle();
    run_txn(8'h12, 8'h99, -1, -1);
    next_cycle();
    run_txn(8'h80, 8'h01, -1, -1);
    next_cycle();

    for (int k = 0; k < 4; k++) begin
      ra = 8'($urandom_range(0, 255));
      rd = 8'($urandom_range(0, 255));
      run_txn(ra, rd, -1, -1);
      next_cycle();
    end

    check("protocol_violations", viol, 0);
    check("gap_sclk_low", (gap_min >= CLK_DIV * GAP_HALF && gap_min < 1000), 1);
    check("scoreboard_empty", sb.size(), 0);
    check("captures_consumed", cap_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ext_mem_spi_master.md
Name: ext_mem_spi_master

Overview:
- SPI master that drives the SPI port (CS/SCLK/MOSI/MISO) of the external memory interface.
- One transaction is one CS-low frame of two bytes.
  - Byte 0: address, sent on MOSI.
  - Byte 1: write data, sent on MOSI. During the same byte, the old memory contents at that address are captured from MISO.
- The net effect is an atomic swap: write new data, return previous data.
- Sits between the compute/control logic (simple start/done handshake) and the memory SPI pins.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period. Legal values are 4 and above, because the slave synchronises SCLK into its own clk domain.
- GAP_HALF, 4, SCLK half-periods between byte 0 and byte 1, with SCLK low. Gives the slave time to load its tx buffer. Legal values are 2 and above.
- HOLD_HALF, 2, half-periods that CS stays high after a frame before done. Legal values are 1 and above.

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle request; sampled only in IDLE
- wr_addr  input  8  memory address, latched on an accepted start
- wr_data  input  8  write byte, latched on an accepted start
- busy  output  1  high from the accepted start until done
- done  output  1  one-cycle pulse at the end of a transaction
- rd_data  output  8  previous memory contents captured in byte 1; valid from done until the next done
- CS  output  1  chip select, active-low
- SCLK  output  1  SPI clock, mode 0 (idle low)
- MOSI  output  1  serial data out, MSB first
- MISO  input  1  serial data in

Behaviour:
- Reset values (reset_n low, asynchronous): CS=1, SCLK=0, MOSI=0, busy=0, done=0, rd_data=0x00, state=IDLE, all counters 0.
- Timing base: a divider counts 0..CLK_DIV-1. Each wrap ends one half-period "tick".
- State machine:
  - IDLE:
    - start=1 latches wr_addr and wr_data, sets busy=1, drives CS=0, drives MOSI=addr[7], and goes to CS_SETUP.
  - CS_SETUP:
    - Lasts 1 half-period, then goes to SHIFT_ADDR.
  - SHIFT_ADDR:
    - 16 half-periods, alternating rising and falling SCLK edges.
    - MOSI is stable before each rising edge.
    - On each falling edge, MOSI advances to the next bit.
    - After the 8th falling edge, go to GAP.
  - GAP:
    - SCLK=0 and MOSI=wr_data[7] for GAP_HALF half-periods, then go to SHIFT_DATA.
  - SHIFT_DATA:
    - Same 16 half-periods as SHIFT_ADDR, sending wr_data.
    - MISO is sampled into a shift register on each rising SCLK edge, MSB first.
    - After the 8th falling edge, the shift register is copied to rd_data, CS goes to 1, MOSI goes to 0, and the state goes to CS_HOLD.
  - CS_HOLD:
    - HOLD_HALF half-periods with CS=1, then go to DONE.
  - DONE:
    - done=1 and busy=0 for exactly one cycle, then return to IDLE.
- Latency: done is asserted CLK_DIV*(1+16+GAP_HALF+16+HOLD_HALF) cycles after the edge that accepts start, i.e. 156 with defaults.
- start while busy=1 or in DONE is ignored, with no queueing.
- A new start in the cycle after done is accepted.
- SCLK never toggles while CS=1. CS never changes within a half-period in which SCLK is high.
- rd_data updates only at the end of SHIFT_DATA. An aborted frame leaves it unchanged, except for reset, which clears it.
- Reset asserted mid-frame: CS immediately goes to 1 and SCLK to 0. The slave sees a truncated frame and must not commit a write.
- Any latched wr_addr/wr_data value is legal. Address wrap is not applicable, since the full 8 bits are sent.

Optional Feature:
- Macro: SPI_TXN_COUNT_EN.
- Defined:
  - Adds output txn_count[15:0], reset to 0.
  - Increments by 1 in the DONE cycle and wraps from 0xFFFF to 0x0000.
  - Aborted frames are not counted.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Slave mem[0x12]=0x3C; start with wr_addr=0x12, wr_data=0xA5 -> done after 156 cycles, rd_data=0x3C, slave mem[0x12]=0xA5, MOSI bit stream 0x12 then 0xA5 MSB first.
- Back-to-back: start the cycle after done with addr 0x12, data 0x5A -> rd_data=0xA5, mem[0x12]=0x5A, CS high for at least 2 half-periods between frames.
- start pulsed at cycle 20 of an active frame with addr 0x40 -> ignored, exactly one done, mem[0x40] unchanged.
- reset_n low during the 3rd bit of SHIFT_DATA -> CS=1, SCLK=0, busy=0, rd_data=0 that cycle, slave mem unchanged; next transaction completes normally.
- Mode-0 check with addr 0x80, data 0x01 -> MOSI=1 before the first rising SCLK edge; no SCLK edges while CS=1; SCLK low in GAP.
- SPI_TXN_COUNT_EN defined: 3 complete transactions plus 1 reset-aborted one -> txn_count=3 (reset clears to 0; count after the reset reflects only post-reset completions).
